ram_burst_reader: RTL and testbench
===================================

# ram_burst_reader

Burst read sequencer that sits directly downstream of the synchronous-read data RAM (one-cycle read latency, address registered inside the RAM). On a start command it walks `burst_len` consecutive RAM addresses from `base_addr`, wrapping modulo depth, and streams the words out on a valid/ready interface. A small internal buffer absorbs the RAM latency and downstream backpressure, so throughput is one word per cycle when `m_ready` is held high.

## Interface
- `AWIDTH`, 3: RAM address width; depth = 1 << AWIDTH.
- `DWIDTH`, 32: RAM / stream data width.

- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `base_addr`  in  AWIDTH  first RAM address of the burst.
- `burst_len`  in  AWIDTH+1  number of words; 0 means an empty burst; values above depth are clamped to depth.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `ram_addr`  out  AWIDTH  RAM read address, connected to the RAM `addr` port; `we` is tied low at integration.
- `ram_rdata`  in  DWIDTH  RAM `dout`; data for the address presented in the previous cycle.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DWIDTH  stream word.
- `m_last`  out  1  high with the final word of a burst.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: if `start`=1, latch `base_addr` and the clamped `burst_len`, clear the issue and beat counters, and go to FETCH. If the latched length is 0, go to IDLE instead and pulse `done` in the next cycle.
- FETCH: issue a read (drive `ram_addr` = base + issued, modulo depth) when buffered + in_flight − pop < 2, where pop = `m_valid & m_ready`. Go to DRAIN once issued == len.
- Read data is captured into the 2-entry buffer in the cycle after issue, always, without condition. `ram_addr` is therefore free to change every cycle.
- DRAIN: wait until the buffer is empty and in_flight = 0, then go to IDLE and set `done` for one cycle.
- `m_data` and `m_last` hold stable while `m_valid & !m_ready`. Words are emitted in address order with no loss or duplication.
- `m_last` = 1 only on the beat whose index equals len−1.
- `start` while `busy`: ignored, and no parameters are latched.
- Address arithmetic is AWIDTH bits and wraps naturally. For example, with `base_addr`=6 and `burst_len`=4, the addresses are 6,7,0,1.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `ram_addr`=0. The buffer is flushed and the state is IDLE.
- Reset mid-burst aborts immediately. No `done` is produced and no further beats are emitted.
- `start` in cycle 0: `busy`=1 and `ram_addr`=base in cycle 1; the word is captured at the end of cycle 2; `m_valid`=1 in cycle 3.
- With `m_ready`=1 throughout, beats appear in cycles 3 … 3+len−1 with no bubbles.
- If the final beat is accepted in cycle N, then in cycle N+1 `done`=1 and `busy`=0. A `start` in cycle N+1 is accepted.
- With `m_ready`=0, at most 2 words are buffered and at most 0 reads are in flight beyond them, so no RAM word is ever dropped.

## Configuration
- `RAM_RD_CHECKSUM_EN` defined:
  - Adds output port `checksum`, DWIDTH bits, reset to 0.
  - It is cleared when `start` is accepted and XOR-accumulates every accepted beat.
  - It is final and stable from the `done` cycle until the next accepted `start`.
- `RAM_RD_CHECKSUM_EN` undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- RAM preloaded with mem[i]=32'h1000_0000+i; `base_addr`=0, `burst_len`=8, `m_ready`=1 → beats 32'h1000_0000…32'h1000_0007 in cycles 3–10, `m_last` on cycle 10, `done` in cycle 11; with the macro defined, `checksum`=32'h0000_0000.
- `base_addr`=6, `burst_len`=4 → data from addresses 6,7,0,1; `m_last` on the 4th beat.
- `burst_len`=3 with `m_ready` toggling 1,0,0,1,0,1 → three beats in order, `m_data` held during stalls, no duplicates.
- `burst_len`=0 → `done` one cycle after `start`, `m_valid` never asserted; `burst_len`=12 → exactly 8 beats.
- `start` pulsed mid-burst → ignored, original burst completes unchanged; `reset_n` low after beat 2 of 8 → all outputs 0 next cycle, no `done`; a fresh burst afterwards is correct.

Source files
------------

// File: rtl/ram_burst_reader_if.sv
// Output stream of the RAM burst reader: one word per valid/ready handshake,
// with m_last marking the final word of a burst.
interface ram_burst_reader_if #(
  parameter int DWIDTH = 32
);
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read sequencer for a one-cycle-latency synchronous RAM, streaming words via a 2-entry buffer.
// Optional RAM_RD_CHECKSUM_EN adds an XOR checksum output over the accepted beats.
module ram_burst_reader #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   burst_len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_rdata,
  ram_burst_reader_if.master m
`ifdef RAM_RD_CHECKSUM_EN
  ,
  output logic [DWIDTH-1:0] checksum
`endif
);

  localparam logic [AWIDTH:0] DEPTH_L = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE_L   = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_nx;
  logic [AWIDTH-1:0] base_q;
  logic [AWIDTH:0]   len_q, issued, beat, len_clamped;
  logic              inflight;
  logic [DWIDTH-1:0] buf_q [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop, issue, accept, finish;

  assign pop      = m.m_valid & m.m_ready;
  assign busy     = (state != IDLE);
  assign ram_addr = base_q + issued[AWIDTH-1:0];
  assign m.m_valid = (count != 2'd0);
  assign m.m_data  = buf_q[rd_ptr];
  assign m.m_last  = m.m_valid && (beat == len_q - ONE_L);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Issue only while buffered + in-flight words, less this cycle's pop, leave a free slot.
  always_comb begin
    state_nx    = state;
    issue       = 1'b0;
    accept      = 1'b0;
    finish      = 1'b0;
    len_clamped = (burst_len > DEPTH_L) ? DEPTH_L : burst_len;
    occ         = {1'b0, count} + {2'b00, inflight};
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (len_clamped != '0) state_nx = FETCH;
        end
      end
      FETCH: begin
        issue = (issued != len_q) && (occ < (3'd2 + {2'b00, pop}));
        if (issued == len_q) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!inflight && (count == {1'b0, pop})) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      beat     <= '0;
      inflight <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        len_q  <= len_clamped;
        issued <= '0;
        beat   <= '0;
      end else begin
        if (issue) issued <= issued + ONE_L;
        if (pop)   beat   <= beat + ONE_L;
      end
      inflight <= issue;
      if (inflight) begin
        buf_q[wr_ptr] <= ram_rdata;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      done <= finish | (accept && (len_clamped == '0));
    end
  end

`ifdef RAM_RD_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   checksum <= '0;
    else if (accept) checksum <= '0;
    else if (pop)    checksum <= checksum ^ m.m_data;
  end
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized scoreboard bench for ram_burst_reader with a synchronous-read RAM model;
// checks the checksum output too when RAM_RD_CHECKSUM_EN is defined.
module tb_ram_burst_reader;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   burst_len = '0;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
`ifdef RAM_RD_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_burst_reader_if #(.DWIDTH(DW)) sif();

  ram_burst_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .m         (sif)
`ifdef RAM_RD_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) ram_rdata <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  beat_t         exp_q[$];
  int            checks = 0, errors = 0;
  int            start_cyc = 0, first_valid_cyc = -1, exp_done_cyc = -1;
  int            last_done_cyc = -1, done_seen = 0, done_base = 0, beats_seen = 0;
  logic [DW-1:0] exp_sum = '0;
  int            ready_mode = 0;
  logic          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, done timing
  always @(negedge clock) begin : monitor
    beat_t e;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && !sif.m_valid) chk("valid_dropped_in_stall", 64'(sif.m_valid), 64'd1);
      if (sif.m_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_prev) begin
          chk("hold_data", 64'(sif.m_data), 64'(stall_data));
          chk("hold_last", 64'(sif.m_last), 64'(stall_last));
        end
        if (sif.m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(sif.m_data), 64'hDEAD_BEEF_0000_0000);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(sif.m_data), 64'(e.data));
            chk("beat_last", 64'(sif.m_last), 64'(e.last));
            if (e.last) exp_done_cyc = cyc + 1;
          end
          beats_seen++;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          stall_data = sif.m_data;
          stall_last = sif.m_last;
        end
      end else begin
        stall_prev = 1'b0;
      end
      if (done) begin
        chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
        chk("busy_at_done", 64'(busy), 64'd0);
`ifdef RAM_RD_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(exp_sum));
`endif
        done_seen++;
        last_done_cyc = cyc;
        exp_done_cyc = -1;
      end
    end
  end

  // Ready driver: 0 = always high, 1 = random, 2 = fixed pattern from cycle 3 of the burst
  initial begin : ready_drv
    int k;
    sif.m_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1: sif.m_ready = 1'($urandom_range(0, 1));
        2: begin
          k = cyc - start_cyc - 3;
          sif.m_ready = (k < 0) ? 1'b1 : pat[k % 6];
        end
        default: sif.m_ready = 1'b1;
      endcase
    end
  end

  // Reference: n = min(len, depth) words from (base + i) mod depth, last on i = n-1
  task automatic issue_burst(input int b, input int len);
    beat_t e;
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      e.data = mem[(b + i) % DEPTH];
      e.last = (i == n - 1);
      exp_q.push_back(e);
      exp_sum ^= e.data;
    end
    @(posedge clock);
    #1;
    base_addr = AW'(b);
    burst_len = (AW + 1)'(len);
    start = 1'b1;
    start_cyc = cyc;
    first_valid_cyc = -1;
    done_base = done_seen;
    if (n == 0) exp_done_cyc = start_cyc + 1;
    @(posedge clock);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    burst_len = (AW + 1)'($urandom);
    @(negedge clock);
    chk("busy_cycle1", 64'(busy), 64'(n != 0));
    if (n != 0) chk("ram_addr_cycle1", 64'(ram_addr), 64'(b % DEPTH));
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (done_seen == done_base && t < 300) begin
      @(posedge clock);
      t++;
    end
    #1;
    if (done_seen == done_base) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", nm, t);
    end else begin
      chk({nm, "_done_count"}, 64'(done_seen - done_base), 64'd1);
    end
    chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_m_valid"}, 64'(sif.m_valid), 64'd0);
    chk({nm, "_m_last"}, 64'(sif.m_last), 64'd0);
    chk({nm, "_m_data"}, 64'(sif.m_data), 64'd0);
    chk({nm, "_ram_addr"}, 64'(ram_addr), 64'd0);
`ifdef RAM_RD_CHECKSUM_EN
    chk({nm, "_checksum"}, 64'(checksum), 64'd0);
`endif
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t, b0, d0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Incrementing pattern, full-rate
    ready_mode = 0;
    issue_burst(0, 8);
    wait_done("inc8");
    chk("inc8_first_valid_cycle", 64'(first_valid_cyc - start_cyc), 64'd3);
    chk("inc8_done_cycle", 64'(last_done_cyc - start_cyc), 64'd11);

    // Wrapping address
    fill_random();
    issue_burst(6, 4);
    wait_done("wrap");

    // Backpressure pattern
    ready_mode = 2;
    issue_burst(3, 3);
    wait_done("stall");
    ready_mode = 0;

    // Empty burst
    issue_burst(5, 0);
    wait_done("empty");
    repeat (3) @(posedge clock);
    #1;
    chk("empty_no_valid", 64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

    // Over-long burst is clamped to the depth
    issue_burst(1, 12);
    wait_done("clamp");

    // Start while busy is ignored
    fill_random();
    issue_burst(2, 8);
    repeat (2) @(posedge clock);
    #1;
    base_addr = 3'd5;
    burst_len = 4'd3;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("midstart");

    // Reset after beat 2 of 8 aborts the burst
    fill_random();
    b0 = beats_seen;
    issue_burst(0, 8);
    t = 0;
    while (beats_seen < b0 + 2 && t < 100) begin
      @(negedge clock);
      #1;
      t++;
    end
    chk("abort_beats_reached", 64'(beats_seen >= b0 + 2), 64'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    exp_done_cyc = -1;
    d0 = done_seen;
    @(negedge clock);
    check_zero("abort");
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("abort_no_done", 64'(done_seen), 64'(d0));
    issue_burst(4, 8);
    wait_done("after_abort");

    // Randomized bursts with random backpressure
    ready_mode = 1;
    for (int r = 0; r < 16; r++) begin
      fill_random();
      issue_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 12)));
      wait_done("random");
      repeat (int'($urandom_range(0, 2))) @(posedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
